// File: rtl/mnist_pkg.sv
// Shared MNIST inference types: logit format and classifier result types.
package mnist_pkg;

  localparam int FEATURE_WIDTH = 16;
  localparam int NUM_DIGITS    = 10;

  typedef logic signed [FEATURE_WIDTH-1:0]  feature_type;
  typedef logic [$clog2(NUM_DIGITS)-1:0]    class_index_type;

  typedef struct packed {
    class_index_type index;
    feature_type     score;
  } classify_result_type;

endpackage

// File: rtl/feature_if.sv
// Feature stream between inference layers; one vector of logits per beat.
interface feature_if #(parameter int VECTOR_LENGTH = 1) ();
  logic                  valid;
  logic                  ready;
  mnist_pkg::feature_type features [VECTOR_LENGTH];

  modport source (output valid, output features, input ready);
  modport sink   (input valid, input features, output ready);
endinterface

// File: rtl/argmax_tracker.sv
// Running best / second-best logit datapath. Next-state values are exposed so
// the caller can capture the final compare result on the last beat.
// ARGMAX_MARGIN_EN adds second-best tracking and the margin output.
module argmax_tracker
  import mnist_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       beat_en,
  input  logic                       beat_first,
`ifdef ARGMAX_MARGIN_EN
  input  logic                       beat_second,
`endif
  input  logic [IDX_W-1:0]           beat_idx,
  input  logic [FEATURE_WIDTH-1:0]   logit,
  output logic [IDX_W-1:0]           best_index_nxt,
  output logic [FEATURE_WIDTH-1:0]   best_score_nxt
`ifdef ARGMAX_MARGIN_EN
  , output logic signed [FEATURE_WIDTH:0] margin_nxt
`endif
);

  feature_type       best_score;
  logic [IDX_W-1:0]  best_index;
  logic              beats_best;

  // Strict compare keeps the lower index on ties.
  assign beats_best = $signed(logit) > best_score;

  always_comb begin
    best_score_nxt = best_score;
    best_index_nxt = best_index;
    if (beat_en && (beat_first || beats_best)) begin
      best_score_nxt = logit;
      best_index_nxt = beat_idx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      best_score <= '0;
      best_index <= '0;
    end else begin
      best_score <= best_score_nxt;
      best_index <= best_index_nxt;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  feature_type second_score;
  feature_type second_nxt;

  // Beat 1 fills second unconditionally; a displaced best is demoted.
  always_comb begin
    second_nxt = second_score;
    if (beat_en && !beat_first) begin
      if (beats_best)
        second_nxt = best_score;
      else if (beat_second || ($signed(logit) > second_score))
        second_nxt = logit;
    end
  end

  assign margin_nxt = $signed({best_score_nxt[FEATURE_WIDTH-1], best_score_nxt}) -
                      $signed({second_nxt[FEATURE_WIDTH-1], second_nxt});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) second_score <= '0;
    else          second_score <= second_nxt;
  end
`endif

endmodule

// File: rtl/argmax_classifier.sv
// Final MNIST stage: argmax over NUM_CLASSES logits, result on valid/ready.
// ARGMAX_MARGIN_EN adds class_margin (best minus second-best score).
module argmax_classifier
  import mnist_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset_n,
  feature_if.sink                           features_in,
  output logic                              class_valid,
  input  logic                              class_ready,
  output logic [$clog2(NUM_CLASSES)-1:0]    class_index,
  output logic signed [FEATURE_WIDTH-1:0]   class_score,
  output logic [COUNT_WIDTH-1:0]            images_done
`ifdef ARGMAX_MARGIN_EN
  , output logic signed [FEATURE_WIDTH:0]   class_margin
`endif
);

  localparam int IDX_W = $clog2(NUM_CLASSES);

  typedef enum logic {S_COLLECT, S_RESULT} state_t;

  state_t            state;
  logic [IDX_W-1:0]  beat_cnt;
  logic              ready_q;
  logic              accept;
  logic              last_beat;
  logic [IDX_W-1:0]  index_nxt;
  feature_type       score_nxt;
`ifdef ARGMAX_MARGIN_EN
  logic signed [FEATURE_WIDTH:0] margin_nxt;
`endif

  assign features_in.ready = ready_q;
  assign accept            = features_in.valid && ready_q;
  assign last_beat         = beat_cnt == IDX_W'(NUM_CLASSES - 1);

  argmax_tracker #(.IDX_W(IDX_W)) u_tracker (
    .clock          (clock),
    .reset_n        (reset_n),
    .beat_en        (accept),
    .beat_first     (beat_cnt == '0),
`ifdef ARGMAX_MARGIN_EN
    .beat_second    (beat_cnt == IDX_W'(1)),
`endif
    .beat_idx       (beat_cnt),
    .logit          (features_in.features[0]),
    .best_index_nxt (index_nxt),
    .best_score_nxt (score_nxt)
`ifdef ARGMAX_MARGIN_EN
    , .margin_nxt   (margin_nxt)
`endif
  );

  // Result registers load only on the last beat so they stay put after acceptance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_COLLECT;
      beat_cnt    <= '0;
      ready_q     <= 1'b1;
      class_valid <= 1'b0;
      class_index <= '0;
      class_score <= '0;
      images_done <= '0;
`ifdef ARGMAX_MARGIN_EN
      class_margin <= '0;
`endif
    end else begin
      case (state)
        S_COLLECT: begin
          if (accept) begin
            if (last_beat) begin
              beat_cnt    <= '0;
              class_index <= index_nxt;
              class_score <= score_nxt;
`ifdef ARGMAX_MARGIN_EN
              class_margin <= margin_nxt;
`endif
              ready_q     <= 1'b0;
              class_valid <= 1'b1;
              state       <= S_RESULT;
            end else begin
              beat_cnt <= beat_cnt + IDX_W'(1);
            end
          end
        end
        S_RESULT: begin
          if (class_ready) begin
            images_done <= images_done + COUNT_WIDTH'(1);
            ready_q     <= 1'b1;
            class_valid <= 1'b0;
            state       <= S_COLLECT;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Final stage of the MNIST inference pipeline. Sits directly downstream of the last dense layer, which has OUTPUT_VECTOR_LENGTH = NUM_CLASSES and relu = 0.
- Consumes one logit per beat over a feature_if stream, tracks the running maximum, and after NUM_CLASSES beats presents the winning class index and its score on a valid/ready result port.
- Keeps a running count of classified images for the testbench scoreboard.

Parameters:
- NUM_CLASSES, 10, logits per image; must be ≥ 2.
- COUNT_WIDTH, 16, width of the image counter.

Ports:
- clock, input, 1, single clock; all state on posedge.
- reset_n, input, 1, asynchronous active-low reset.
- features_in, feature_if, -, input stream. Uses valid, ready, features[0]. Logit is feature_type (signed, mnist_pkg).
- class_valid, output, 1, result available.
- class_ready, input, 1, consumer accepts result.
- class_index, output, $clog2(NUM_CLASSES), winning class.
- class_score, output, feature_type, winning logit.
- images_done, output, COUNT_WIDTH, number of results accepted since reset.

Behaviour:
- Reset (async, reset_n low):
  - state=S_COLLECT, beat counter=0, best_score=0, best_index=0.
  - class_valid=0, class_index=0, class_score=0, images_done=0.
  - features_in.ready=1 in the first cycle after reset deasserts.
- States: S_COLLECT, S_RESULT.
- S_COLLECT:
  - features_in.ready=1, class_valid=0.
  - A beat is accepted when valid && ready.
  - Beat 0 (counter==0): load best_score=logit, best_index=0 unconditionally.
  - Beat k>0: if logit > best_score (signed, strict), load best_score=logit, best_index=k.
  - Ties keep the lower index.
  - Counter increments per accepted beat.
  - On the accept with counter==NUM_CLASSES-1: counter wraps to 0, the final compare result is registered, and the next state is S_RESULT.
  - No beat is accepted while valid=0; gaps of any length are allowed.
- S_RESULT:
  - features_in.ready=0, so upstream stalls. class_valid=1.
  - class_index and class_score are driven from registers and held stable while class_valid=1 && class_ready=0.
  - On class_valid && class_ready: images_done increments and wraps modulo 2^COUNT_WIDTH; next state is S_COLLECT.
- Latency:
  - class_valid asserts the cycle after the last logit is accepted.
  - Throughput is NUM_CLASSES+1 cycles per image with class_ready tied high.
- Comparison: full signed feature_type width, no truncation, no saturation.
- class_index and class_score retain their last values after acceptance; they are don't-care-free (never X) after reset.
- Reset mid-image or mid-result: all partial state is discarded, nothing is emitted, and images_done clears.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- Defined:
  - Adds output port class_margin, feature_type width + 1, signed.
  - class_margin = best_score − second_best_score, valid with class_valid.
  - second_best is tracked alongside best. When a new best arrives, the old best is demoted to second.
  - Ties give margin 0.
  - Margin reset value is 0.
- Undefined: port and second-best registers are absent; all other behaviour is identical.

Decomposition:
- mnist_pkg gains:
  - NUM_DIGITS = 10.
  - typedef class_index_type = logic [$clog2(NUM_DIGITS)-1:0].
  - typedef classify_result_type struct {class_index_type index; feature_type score;}.
- Sub-module argmax_tracker holds the compare/update datapath: best, second best, index registers, load/update controls. The top level keeps the FSM, counters and handshakes.

Test Plan:
- Logits [3,−2,7,1,0,5,7,−9,2,4], class_ready=1 → class_index=2, class_score=7 (tie at 6 loses); with macro, class_margin=0.
- All ten logits negative [−5,−1,−8,…,−3] → class_index=1, score=−1 (signed compare; no zero default wins).
- Hold class_ready=0 for 20 cycles after result → class_valid stays 1 with stable outputs, features_in.ready=0, upstream beats not consumed; then ready=1 → images_done=1.
- Three back-to-back images with random valid gaps, winners 9, 0, 4 → three results in order, images_done=3, no dropped beats.
- Assert reset_n low after 5 logits, then send a full image with winner 6 → only one result (6); images_done=1.
- COUNT_WIDTH=2, five images → images_done wraps 3→0→1.
